// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: EX operand forwarding from MA/WB tags with load-use stall and stall statistics
module fwd_scoreboard #(
  parameter int NPORT = 2,
  parameter int DW = 32,
  parameter int RW = 5,
  parameter bit LOAD_FWD_MA = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  input  logic [RW-1:0]       ex_rd,
  input  logic                ex_wen,
  input  logic                ex_load,
  input  logic [NPORT*RW-1:0] ex_src,
  input  logic [NPORT*DW-1:0] ex_rf_data,
  input  logic [DW-1:0]       ma_val_rf_w_tmp,
  input  logic [DW-1:0]       ma_mem_rdata,
  input  logic [DW-1:0]       wb_val_rf_data_w,
  input  logic                flush,
  input  logic                stat_clr,
  output logic [NPORT*DW-1:0] ex_fwd,
  output logic                ex_stall,
  output logic [NPORT*2-1:0]  fwd_sel,
  output logic [31:0]         stat_stall
);
  logic          ma_v, ma_wen, ma_load, wb_v, wb_wen;
  logic [RW-1:0] ma_rd, wb_rd;
  logic [NPORT-1:0] ld_hit;
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic [RW-1:0] src;
    logic          ma_hit, wb_hit;
    logic [1:0]    sel;
    assign src    = ex_src[p*RW +: RW];
    assign ma_hit = ma_v && ma_wen && ma_rd == src && src != '0;
    assign wb_hit = wb_v && wb_wen && wb_rd == src && src != '0;
    assign ld_hit[p] = ma_hit && ma_load && !LOAD_FWD_MA;
    // an unforwardable load hit falls back to RF data; the stall discards it anyway
    assign sel = ma_hit ? (ma_load ? (LOAD_FWD_MA ? 2'd3 : 2'd0) : 2'd1) : wb_hit ? 2'd2 : 2'd0;
    assign fwd_sel[p*2 +: 2] = sel;
    assign ex_fwd[p*DW +: DW] = src == '0 ? '0 :
                                sel == 2'd1 ? ma_val_rf_w_tmp :
                                sel == 2'd2 ? wb_val_rf_data_w :
                                sel == 2'd3 ? ma_mem_rdata : ex_rf_data[p*DW +: DW];
  end
  assign ex_stall = ex_valid && |ld_hit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ma_v    <= 1'b0;
      ma_rd   <= '0;
      ma_wen  <= 1'b0;
      ma_load <= 1'b0;
      wb_v    <= 1'b0;
      wb_rd   <= '0;
      wb_wen  <= 1'b0;
    end else begin
      ma_v    <= !flush && ex_valid && !ex_stall;
      ma_rd   <= ex_rd;
      ma_wen  <= ex_wen;
      ma_load <= ex_load;
      wb_v    <= !flush && ma_v;
      wb_rd   <= ma_rd;
      wb_wen  <= ma_wen;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stat_stall <= '0;
    else if (stat_clr) stat_stall <= '0;
    else if (ex_stall && stat_stall != 32'hFFFF_FFFF) stat_stall <= stat_stall + 32'd1;
endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter NPORT, default 2, number of EX source-operand ports (1..4).
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter RW, default 5, register-index width.
REQ-004 Parameter LOAD_FWD_MA, default 0; 1 = load data forwards from MA read data without stall.
REQ-005 Ports: clk in 1, rising-edge clock; rst_n in 1, reset, asynchronous, active-low.
REQ-006 ex_valid in 1, EX holds a real instruction.
REQ-007 ex_rd in RW, EX destination index; ex_wen in 1, EX writes rd; ex_load in 1, EX is a load.
REQ-008 ex_src in NPORT*RW, source indices, port p at bits [p*RW +: RW].
REQ-009 ex_rf_data in NPORT*DW, register-file read data per port.
REQ-010 ma_val_rf_w_tmp in DW, MA ALU result; ma_mem_rdata in DW, MA load data.
REQ-011 wb_val_rf_data_w in DW, WB write-back value.
REQ-012 flush in 1, kill all in-flight tags.
REQ-013 ex_fwd in NPORT*DW, forwarded operands (combinational).
REQ-014 ex_stall out 1, hold IF/ID/EX this cycle (combinational).
REQ-015 fwd_sel out NPORT*2, per-port source: 0 RF, 1 MA-tmp, 2 WB, 3 MA-load.
REQ-016 stat_stall out 32, saturating stall-cycle counter; stat_clr in 1, synchronous clear.

Function
REQ-017 Internal tags: MA tag {v,rd,wen,load}, WB tag {v,rd,wen}, registered.
REQ-018 Tag "hits" port p when v=1, wen=1, rd==src_p, src_p!=0.
REQ-019 Per port priority: MA hit over WB hit over RF; index 0 always RF, ex_fwd=0.
REQ-020 MA hit, MA not load: ex_fwd_p=ma_val_rf_w_tmp, sel=1.
REQ-021 MA hit, MA load, LOAD_FWD_MA=1: ex_fwd_p=ma_mem_rdata, sel=3, no stall.
REQ-022 MA hit, MA load, LOAD_FWD_MA=0: ex_stall=1, sel=0, ex_fwd_p=ex_rf_data_p.
REQ-023 WB hit only: ex_fwd_p=wb_val_rf_data_w, sel=2; no hit: ex_rf_data_p, sel=0.
REQ-024 ex_stall asserts only if ex_valid=1 and at least one port meets REQ-022; ports evaluated independently.
REQ-025 Each edge, no stall: MA tag <= {ex_valid,ex_rd,ex_wen,ex_load}; WB tag <= MA tag.
REQ-026 Each edge, stall: MA tag <= bubble (v=0); WB tag <= MA tag; stall lasts exactly 1 cycle per load-use.
REQ-027 flush=1 at edge: both tags v=0, overrides REQ-025/026; ex_stall still combinationally reported that cycle.
REQ-028 stat_stall +1 per edge with ex_stall=1, holds at 0xFFFFFFFF; stat_clr wins over increment.
REQ-029 Port 0 and port p logic identical; no cross-port dependency except shared ex_stall.

Reset
REQ-030 rst_n low: both tags v=0, rd=0, stat_stall=0 immediately, independent of clk.
REQ-031 Out of reset with tags empty: ex_stall=0, all sel=0, ex_fwd=ex_rf_data.
REQ-032 Reset asserted mid-stall: stall drops at once; first post-reset cycle forwards nothing.

Verification
REQ-033 EX add rd=3; next EX src0=3, ma_val_rf_w_tmp=0x11 -> ex_fwd0=0x11, sel0=1, ex_stall=0.
REQ-034 Same rd=3 two cycles back, wb_val_rf_data_w=0x22, newer MA rd=3 tmp=0x33 -> port picks 0x33 (MA priority).
REQ-035 LOAD_FWD_MA=0, load rd=5 then src1=5 -> ex_stall=1 one cycle, stat_stall=1, next cycle sel1=2 from WB.
REQ-036 LOAD_FWD_MA=1, same sequence, ma_mem_rdata=0xAB -> sel1=3, ex_fwd1=0xAB, no stall.
REQ-037 src=0 with MA rd=0 wen=1 -> ex_fwd=0, sel=0; flush after rd=7 write -> next src=7 reads RF.
REQ-038 stat_stall preset near 0xFFFFFFFF, continuous stalls -> saturates; stat_clr with stall -> 0.
